// File: rtl/bsg_clk_gen_pearl_pkg.sv
// Shared constants and helpers for the clock-generator pearl.
package bsg_clk_gen_pearl_pkg;

   // Half-period-minus-one that reproduces the old fixed divide-by-30 monitor.
   localparam int bsg_clk_gen_pearl_monitor_div_legacy_gp = 14;

   function automatic int bsg_clk_gen_pearl_monitor_period(input int div);
      return 2 * (div + 1);
   endfunction

endpackage

// File: rtl/bsg_clk_gen_pearl_monitor_edge_ctr.sv
// Wrapping up-counter; advances by one on each cycle inc_i is high.
module bsg_clk_gen_pearl_monitor_edge_ctr #(
   parameter int width_p = 16
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               inc_i,
   output logic [width_p-1:0] count_o
);

   always_ff @(posedge clk_i) begin
      if (reset_i)
         count_o <= '0;
      else if (inc_i)
         count_o <= count_o + width_p'(1);
   end

endmodule

// File: rtl/bsg_clk_gen_pearl_monitor_prog.sv
// Programmable-ratio monitor clock divider with deferred, glitch-free ratio updates
// and a rising-edge counter.
module bsg_clk_gen_pearl_monitor_prog
   import bsg_clk_gen_pearl_pkg::*;
#(
   parameter int div_width_p   = 8,
   parameter int reset_div_p   = bsg_clk_gen_pearl_monitor_div_legacy_gp,
   parameter int count_width_p = 16
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic                     en_i,
   input  logic                     cfg_v_i,
   input  logic [div_width_p-1:0]   cfg_div_i,
   output logic                     cfg_ready_o,
   output logic                     clk_monitor_o,
   output logic                     applied_o,
   output logic [count_width_p-1:0] edge_count_o
);

   logic [div_width_p-1:0] div_r;
   logic [div_width_p-1:0] cnt_r;
   logic [div_width_p-1:0] pend_div_r;
   logic                   pend_v_r;
   logic                   running;
   logic                   tc;
   logic                   boundary;
   logic                   rise;

   // A disable only takes effect once the output is low, so high phases never get cut short.
   assign running  = en_i | clk_monitor_o;
   assign tc       = (cnt_r == div_r);
   assign boundary = pend_v_r & ((running & tc & clk_monitor_o) | ~running);
   assign rise     = running & tc & ~clk_monitor_o;

   assign cfg_ready_o = ~pend_v_r;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         div_r         <= div_width_p'(reset_div_p);
         cnt_r         <= '0;
         clk_monitor_o <= 1'b0;
         pend_div_r    <= '0;
         pend_v_r      <= 1'b0;
         applied_o     <= 1'b0;
      end else begin
         if (!running) begin
            cnt_r         <= '0;
            clk_monitor_o <= 1'b0;
         end else if (tc) begin
            cnt_r         <= '0;
            clk_monitor_o <= ~clk_monitor_o;
         end else begin
            cnt_r <= cnt_r + div_width_p'(1);
         end

         applied_o <= boundary;

         // Accept and apply are exclusive: accept needs an empty pending slot.
         if (boundary) begin
            div_r    <= pend_div_r;
            pend_v_r <= 1'b0;
         end else if (cfg_v_i && !pend_v_r) begin
            pend_div_r <= cfg_div_i;
            pend_v_r   <= 1'b1;
         end
      end
   end

   bsg_clk_gen_pearl_monitor_edge_ctr #(
      .width_p (count_width_p)
   ) edge_ctr (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .inc_i   (rise),
      .count_o (edge_count_o)
   );

endmodule

// File: tb/tb_bsg_clk_gen_pearl_monitor_prog.sv
// Randomized bench for bsg_clk_gen_pearl_monitor_prog against a phase-length reference model.
module tb_bsg_clk_gen_pearl_monitor_prog;
   import bsg_clk_gen_pearl_pkg::*;

   logic        clk_i = 1'b0;
   logic        reset_i = 1'b1;
   logic        en_i = 1'b0;
   logic        cfg_v_i = 1'b0;
   logic [7:0]  cfg_div_i = '0;
   logic        cfg_ready_o;
   logic        clk_monitor_o;
   logic        applied_o;
   logic [15:0] edge_count_o;
   logic        cfg_ready_s, clk_monitor_s, applied_s;
   logic [1:0]  edge_count_s;

   int total = 0;
   int bad   = 0;

   // reference model: output level, cycles left in current phase, divide values, edge count
   int m_mon, m_left, m_div, m_pend, m_pend_v, m_applied, m_count;

   always #5 clk_i = ~clk_i;

   bsg_clk_gen_pearl_monitor_prog dut (
      .clk_i(clk_i), .reset_i(reset_i), .en_i(en_i), .cfg_v_i(cfg_v_i),
      .cfg_div_i(cfg_div_i), .cfg_ready_o(cfg_ready_o), .clk_monitor_o(clk_monitor_o),
      .applied_o(applied_o), .edge_count_o(edge_count_o)
   );

   bsg_clk_gen_pearl_monitor_prog #(.count_width_p(2)) dut_small (
      .clk_i(clk_i), .reset_i(reset_i), .en_i(en_i), .cfg_v_i(cfg_v_i),
      .cfg_div_i(cfg_div_i), .cfg_ready_o(cfg_ready_s), .clk_monitor_o(clk_monitor_s),
      .applied_o(applied_s), .edge_count_o(edge_count_s)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_div = bsg_clk_gen_pearl_monitor_div_legacy_gp;
      m_mon = 0; m_pend = 0; m_pend_v = 0; m_applied = 0; m_count = 0;
      m_left = m_div + 1;
   endfunction

   function automatic void model_step();
      int run, toggle, bnd;
      if (reset_i) begin
         model_reset();
         return;
      end
      run    = (en_i || m_mon != 0) ? 1 : 0;
      toggle = 0;
      if (run != 0) begin
         m_left--;
         if (m_left == 0) toggle = 1;
      end
      bnd = (m_pend_v != 0 && (run == 0 || (toggle != 0 && m_mon != 0))) ? 1 : 0;
      m_applied = bnd;
      if (bnd != 0) begin
         m_div = m_pend; m_pend_v = 0;
      end else if (cfg_v_i && m_pend_v == 0) begin
         m_pend = int'(cfg_div_i); m_pend_v = 1;
      end
      if (toggle != 0) begin
         if (m_mon == 0) m_count++;
         m_mon = 1 - m_mon;
      end
      if (toggle != 0 || run == 0) m_left = m_div + 1;
   endfunction

   task automatic cycle();
      @(posedge clk_i);
      model_step();
      #1;
      check_eq("clk_monitor", 32'(clk_monitor_o), 32'(m_mon));
      check_eq("applied", 32'(applied_o), 32'(m_applied));
      check_eq("cfg_ready", 32'(cfg_ready_o), 32'(m_pend_v == 0));
      check_eq("edge_count", 32'(edge_count_o), 32'(m_count % 65536));
      check_eq("edge_count_w2", 32'(edge_count_s), 32'(m_count % 4));
      check_eq("small_mon", 32'(clk_monitor_s), 32'(m_mon));
   endtask

   // cycles until the next 0->1 of clk_monitor_o, bounded
   task automatic cycles_to_rise(output int n);
      logic prev;
      int   timeout;
      prev = clk_monitor_o;
      n = 0;
      timeout = 1;
      for (int i = 0; i < 2000; i++) begin
         cycle();
         n++;
         if (clk_monitor_o && !prev) begin
            timeout = 0;
            break;
         end
         prev = clk_monitor_o;
      end
      check_eq("rise_timeout", 32'(timeout), 32'd0);
   endtask

   task automatic send_cfg(input logic [7:0] d);
      cfg_v_i = 1'b1; cfg_div_i = d;
      cycle();
      cfg_v_i = 1'b0;
   endtask

   initial begin
      int n;
      int ap;
      model_reset();
      reset_i = 1'b1;
      cycle(); cycle();
      reset_i = 1'b0;
      check_eq("rst_ready", 32'(cfg_ready_o), 32'd1);
      check_eq("rst_mon", 32'(clk_monitor_o), 32'd0);
      check_eq("rst_count", 32'(edge_count_o), 32'd0);

      // default ratio: first rise after 15 cycles, period 30
      en_i = 1'b1;
      cycles_to_rise(n); check_eq("first_rise", 32'(n), 32'd15);
      cycles_to_rise(n); check_eq("period_30", 32'(n), 32'd30);
      cycles_to_rise(n); check_eq("count_3", 32'(edge_count_o), 32'd3);

      // ratio change mid high phase takes effect only after the fall
      cycle(); cycle(); cycle();
      send_cfg(8'd4);
      check_eq("ready_drop", 32'(cfg_ready_o), 32'd0);
      cycles_to_rise(n); check_eq("post_cfg_rise", 32'(n), 32'd16);
      check_eq("ready_back", 32'(cfg_ready_o), 32'd1);
      cycles_to_rise(n); check_eq("period_10", 32'(n), 32'd10);

      // idle apply of div=0, then clk/2
      en_i = 1'b0;
      repeat (12) cycle();
      send_cfg(8'd0);
      cycle();
      check_eq("idle_apply", 32'(applied_o), 32'd1);
      en_i = 1'b1;
      cycles_to_rise(n); check_eq("div0_first", 32'(n), 32'd1);
      cycles_to_rise(n); check_eq("div0_period", 32'(n), 32'd2);

      // idle change to div=9, then second cfg while pending is dropped
      en_i = 1'b0;
      repeat (4) cycle();
      send_cfg(8'd9);
      cycle();
      en_i = 1'b1;
      cycles_to_rise(n); check_eq("div9_first", 32'(n), 32'd10);
      send_cfg(8'd2);
      send_cfg(8'd6);
      ap = 0;
      for (int i = 0; i < 40; i++) begin
         cycle();
         if (applied_o) ap++;
      end
      check_eq("single_apply", 32'(ap), 32'd1);

      // disable 3 cycles into a high phase: high completes, then idle
      en_i = 1'b0; send_cfg(8'd9); cycle(); en_i = 1'b1;
      cycles_to_rise(n);
      cycle(); cycle();
      en_i = 1'b0;
      cycle();
      ap = 0;
      for (int i = 0; i < 7; i++) begin
         if (clk_monitor_o) ap++;
         cycle();
      end
      check_eq("high_finish", 32'(ap), 32'd7);
      check_eq("held_low", 32'(clk_monitor_o), 32'd0);

      // reset with a config pending
      en_i = 1'b1;
      cycles_to_rise(n);
      send_cfg(8'd3);
      reset_i = 1'b1; cycle(); reset_i = 1'b0;
      check_eq("rst_mid_ready", 32'(cfg_ready_o), 32'd1);
      check_eq("rst_mid_count", 32'(edge_count_o), 32'd0);
      cycles_to_rise(n); check_eq("rst_first_rise", 32'(n), 32'd15);
      cycles_to_rise(n); check_eq("rst_period", 32'(n), 32'd30);

      // randomized traffic
      for (int i = 0; i < 6000; i++) begin
         if ($urandom_range(0, 39) == 0) en_i = ~en_i;
         cfg_v_i   = ($urandom_range(0, 15) == 0);
         cfg_div_i = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255))
                                                 : 8'($urandom_range(0, 6));
         reset_i   = ($urandom_range(0, 799) == 0);
         cycle();
      end
      reset_i = 1'b0; cfg_v_i = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bsg_clk_gen_pearl_monitor_prog.md
Name: bsg_clk_gen_pearl_monitor_prog

Overview:
Programmable-ratio, glitch-free clock monitor divider for the clock-generator pearl. It replaces the fixed divide-by-30 downsampler with a runtime-programmable half-period and a clean enable/disable. It also provides a rising-edge counter so the monitored clock can be checked both on the pad and through software.
- Divide-ratio changes are deferred to a period boundary, so clk_monitor_o never emits a runt pulse.
- Sits after the monitor clock buffer. Config is driven by bsg_tag clients outside this block.

Parameters:
div_width_p, 8, width of half-period-minus-one divide value
reset_div_p, 14, divide value loaded at reset (14 gives period 30, matching the legacy monitor ratio)
count_width_p, 16, width of rising-edge counter

Ports:
clk_i  in  1  clock being monitored; sole clock of the block
reset_i  in  1  synchronous, active-high reset
en_i  in  1  enable output toggling
cfg_v_i  in  1  new divide value valid
cfg_div_i  in  div_width_p  new half-period minus one
cfg_ready_o  out  1  config can be accepted (no pending config)
clk_monitor_o  out  1  divided clock, driven directly from a flop
applied_o  out  1  one-cycle pulse: a new divide value is now in effect
edge_count_o  out  count_width_p  count of clk_monitor_o rising edges; wraps modulo 2^count_width_p

Behaviour:
- Reset values:
  - div_r=reset_div_p
  - cnt_r=0
  - clk_monitor_o=0
  - pending valid=0
  - applied_o=0
  - edge_count_o=0
  - cfg_ready_o=1
- Reset mid-operation discards any pending config and restores these values on the next edge.
- running = en_i | clk_monitor_o. Disable therefore always completes the current high phase.
- Running cycle, cnt_r==div_r: cnt_r<=0 and clk_monitor_o<=~clk_monitor_o.
- Running cycle, otherwise: cnt_r<=cnt_r+1.
- Not running: cnt_r<=0 and clk_monitor_o holds 0 (idle).
- Timing consequences:
  - Output period is 2*(div_r+1) cycles at 50% duty.
  - The first rising edge occurs div_r+1 cycles after en_i is first sampled high from idle.
  - cfg_div_i=0 gives clk_i/2. The all-ones value gives the maximum period, 2^(div_width_p+1).
- Config handshake:
  - Accept when cfg_v_i & cfg_ready_o. The value is captured into the pending register and pending valid is set.
  - cfg_ready_o = ~pending valid (state only, no combinational path from cfg_v_i).
  - cfg_v_i while not ready is ignored; no error is flagged.
- Apply:
  - Boundary = pending valid & ((running & cnt_r==div_r & clk_monitor_o==1) | ~running). This is a falling toggle or idle.
  - At the boundary, div_r<=pending value and pending valid<=0.
  - applied_o is high for exactly the next cycle, which is the first cycle using the new div_r.
- Simultaneous events:
  - A config accepted in a cycle is never applied in that same cycle. Apply uses registered pending state, so the earliest apply is the following cycle (when idle).
  - Accept and apply cannot coincide because accept requires pending valid=0.
  - A new config may be accepted the cycle after apply, since cfg_ready_o is high again.
- The current half-period (high phase) always completes with the old div_r. The low phase after the boundary uses the new value.
- Edge counter: edge_count_o increments on every 0->1 transition of clk_monitor_o and wraps to 0 from all-ones without flagging.
- en_i deasserted during the low phase: the output stays 0 and cnt_r clears on the next edge.
- en_i toggled high for one cycle from idle: the counter starts; if en_i drops before cnt_r reaches div_r, the block returns to idle with no output edge.

Decomposition:
- Package bsg_clk_gen_pearl_pkg gains the legacy constant bsg_clk_gen_pearl_monitor_div_legacy_gp=14.
- The edge counter is a natural sub-module: bsg_clk_gen_pearl_monitor_edge_ctr (wrapping up-counter with an increment strobe).
- The divider, toggle and apply logic stay in the top module.

Test Plan:
- Reset, then en_i=1 with default div -> first rising edge of clk_monitor_o 15 cycles after the first enabled edge; period 30; edge_count_o=3 after 3 periods.
- While running at div=14, send cfg_div_i=4 mid high phase -> cfg_ready_o drops; the high phase lasts 15 cycles; applied_o pulses once after the fall; the following low/high phases are 5 cycles each; cfg_ready_o returns to 1.
- With en_i=0 idle, send cfg_div_i=0 -> applied_o the cycle after acceptance; on enabling, the output toggles every cycle (period 2).
- Send a second cfg while pending -> it is ignored; the first value takes effect; no second applied_o.
- Drop en_i 3 cycles into a high phase of div=9 -> the output stays high 7 more cycles, then holds 0; cnt_r=0; no further edges.
- Assert reset_i mid high phase with a config pending -> the next cycle shows all reset values; the pending config is never applied; the default period 30 resumes.
- count_width_p=2: run 5 rising edges -> edge_count_o sequence 1,2,3,0,1.
